controle_multiciclo: RTL

Multi-cycle control unit for the processor core, replacing the single-cycle decoder. Sequences each instruction through fetch, decode, execute, memory and write-back states; holds memory requests until the memory acknowledges them. Halts on STOP or on a memory timeout. Sits between the instruction register/flags and the datapath muxes, register file, PC and data memory.

---
 rtl/controle_pkg.sv | 42 ++++
 rtl/contador_espera.sv | 32 +++
 rtl/controle_multiciclo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// Purpose: shared opcodes, FSM state encoding and ULA control encodings for the multi-cycle control unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Ports: none.
package controle_pkg;

  // Instruction opcodes as held in the instruction register
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_COPY   = 3'b001;
  localparam logic [2:0] OP_READ   = 3'b010;
  localparam logic [2:0] OP_WRITE  = 3'b011;
  localparam logic [2:0] OP_IFZERO = 3'b100;
  localparam logic [2:0] OP_JUMP   = 3'b101;
  localparam logic [2:0] OP_SET    = 3'b110;
  localparam logic [2:0] OP_STOP   = 3'b111;

  // ULA operation select
  localparam logic [1:0] ULAOP_SOMA    = 2'b00;
  localparam logic [1:0] ULAOP_PASSA_B = 2'b01;

  // ULA B-operand source select
  localparam logic [1:0] ULAF_REG    = 2'b00;
  localparam logic [1:0] ULAF_DESLOC = 2'b01;
  localparam logic [1:0] ULAF_IMED   = 2'b10;

  typedef enum logic [2:0] {
    S_INICIO,
    S_BUSCA,
    S_DECODIFICA,
    S_EXECUTA,
    S_MEMORIA,
    S_ESCRITA,
    S_PARADO,
    S_ERRO
  } estado_t;

  // True for the opcodes that need a data-memory access phase
  function automatic logic acessa_mem(input logic [2:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Purpose: counts consecutive memory-wait cycles and flags when the wait budget is exhausted.
// Latency: o_estouro is combinational on i_enable in the cycle the budget is used up.
// Backpressure: none; the owner decides what to do with o_estouro.
// Ports: i_clock, i_reset (sync, active-high), i_clear (zero the count), i_enable (this cycle is a
//        wait cycle), o_estouro (this wait cycle is the ESPERA_MAX-th in a row).
module contador_espera #(
  parameter int ESPERA_MAX = 15
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_estouro
);

  localparam int W = (ESPERA_MAX < 2) ? 1 : $clog2(ESPERA_MAX);
  // r_cont holds the waits already spent; the current wait is the last allowed one at LIMITE
  localparam logic [W-1:0] LIMITE = W'(ESPERA_MAX - 1);

  logic [W-1:0] r_cont;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_cont <= '0;
    end else if (i_enable && (r_cont != LIMITE)) begin
      r_cont <= r_cont + W'(1);
    end
  end

  assign o_estouro = i_enable && (r_cont == LIMITE);

endmodule

// File: rtl/controle_multiciclo.sv
// Purpose: multi-cycle control unit sequencing fetch/decode/execute/memory/write-back for the core.
// Latency: 4 cycles per non-memory instruction, 5 for READ/WRITE, plus 1 per memory wait cycle.
// Backpressure: memory requests are held until mem_pronto; ESPERA_MAX straight waits -> ERRO.
// Ports: clock, reset (sync, active-high), opcode, BitVerificacao (flags), mem_pronto (memory ack);
//        STOP, erro, EscPC, EscReg, EscMEM, LerMEM, Ji, Beqz, ULAOp, ULAFonte, EndFonte_MEM,
//        FonteEscReg, RegFonte (datapath controls), instr_retiradas (retired-instruction count).
// Build option: define CONTROLE_CONTADOR_EN to include the retired-instruction counter;
//        otherwise instr_retiradas is tied to 0.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int ESPERA_MAX   = 15,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              opcode,
  input  logic [1:0]              BitVerificacao,
  input  logic                    mem_pronto,
  output logic                    STOP,
  output logic                    erro,
  output logic                    EscPC,
  output logic                    EscReg,
  output logic                    EscMEM,
  output logic                    LerMEM,
  output logic                    Ji,
  output logic                    Beqz,
  output logic [1:0]              ULAOp,
  output logic [1:0]              ULAFonte,
  output logic                    EndFonte_MEM,
  output logic                    FonteEscReg,
  output logic                    RegFonte,
  output logic [LARGURA_CONT-1:0] instr_retiradas
);

  estado_t    r_estado;
  estado_t    w_prox;
  logic [2:0] r_opcode;
  logic       w_espera_en;
  logic       w_estouro;
  logic       w_troca;
  logic       w_zero;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= S_INICIO;
      r_opcode <= OP_ADD;
    end else begin
      r_estado <= w_prox;
      if (r_estado == S_DECODIFICA) begin
        r_opcode <= opcode;
      end
    end
  end

  // A wait cycle is any cycle with an outstanding memory request and no acknowledge
  assign w_espera_en = ((r_estado == S_BUSCA) || (r_estado == S_MEMORIA)) && !mem_pronto;
  assign w_troca     = (w_prox != r_estado);

  contador_espera #(
    .ESPERA_MAX(ESPERA_MAX)
  ) u_espera (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (w_troca),
    .i_enable (w_espera_en),
    .o_estouro(w_estouro)
  );

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      S_INICIO:     w_prox = S_BUSCA;
      // mem_pronto is checked first so an acknowledge on the last allowed cycle still succeeds
      S_BUSCA: begin
        if (mem_pronto)     w_prox = S_DECODIFICA;
        else if (w_estouro) w_prox = S_ERRO;
      end
      S_DECODIFICA: w_prox = (opcode == OP_STOP) ? S_PARADO : S_EXECUTA;
      S_EXECUTA:    w_prox = acessa_mem(r_opcode) ? S_MEMORIA : S_ESCRITA;
      S_MEMORIA: begin
        if (mem_pronto)     w_prox = S_ESCRITA;
        else if (w_estouro) w_prox = S_ERRO;
      end
      S_ESCRITA:    w_prox = S_BUSCA;
      S_PARADO:     w_prox = S_PARADO;
      S_ERRO:       w_prox = S_ERRO;
      default:      w_prox = S_INICIO;
    endcase
  end

  // Overflow flag (bit 1) plays no part in branching; it is folded in as a constant-false term
  // so the whole flags bus stays referenced.
  assign w_zero = BitVerificacao[0] & ~(BitVerificacao[1] & 1'b0);

  // ---------------------------------------------------------------- Moore outputs
  always_comb begin
    STOP         = 1'b0;
    erro         = 1'b0;
    EscPC        = 1'b0;
    EscReg       = 1'b0;
    EscMEM       = 1'b0;
    LerMEM       = 1'b0;
    Ji           = 1'b0;
    Beqz         = 1'b0;
    ULAOp        = ULAOP_SOMA;
    ULAFonte     = ULAF_REG;
    EndFonte_MEM = 1'b0;
    FonteEscReg  = 1'b0;
    RegFonte     = 1'b0;
    case (r_estado)
      S_BUSCA: begin
        LerMEM = 1'b1;
      end
      S_EXECUTA: begin
        case (r_opcode)
          OP_COPY: begin
            ULAOp = ULAOP_PASSA_B;
          end
          OP_SET: begin
            ULAOp    = ULAOP_PASSA_B;
            ULAFonte = ULAF_IMED;
          end
          OP_READ, OP_WRITE: begin
            ULAFonte = ULAF_DESLOC;
          end
          default: begin
          end
        endcase
      end
      S_MEMORIA: begin
        EndFonte_MEM = 1'b1;
        LerMEM       = (r_opcode == OP_READ);
        EscMEM       = (r_opcode == OP_WRITE);
      end
      S_ESCRITA: begin
        EscPC       = 1'b1;
        EscReg      = (r_opcode == OP_ADD) || (r_opcode == OP_COPY) ||
                      (r_opcode == OP_SET) || (r_opcode == OP_READ);
        FonteEscReg = (r_opcode == OP_READ);
        RegFonte    = (r_opcode == OP_SET);
        Ji          = (r_opcode == OP_JUMP);
        // Branch is resolved on the live zero flag during write-back
        Beqz        = (r_opcode == OP_IFZERO) && w_zero;
      end
      S_PARADO: begin
        STOP = 1'b1;
      end
      S_ERRO: begin
        STOP = 1'b1;
        erro = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------- retired-instruction counter
`ifdef CONTROLE_CONTADOR_EN
  logic [LARGURA_CONT-1:0] r_retiradas;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_retiradas <= '0;
    end else if ((r_estado == S_ESCRITA) && (r_retiradas != '1)) begin
      r_retiradas <= r_retiradas + LARGURA_CONT'(1);
    end
  end

  assign instr_retiradas = r_retiradas;
`else
  assign instr_retiradas = '0;
`endif

endmodule
